kb_input_fifo: RTL and testbench
================================

Name: kb_input_fifo

Overview:
- Parametrised keypad/key-bus input port; successor to the single-register keypad latch.
- Synchronises an asynchronous key strobe and detects its rising edge. Each detected press pushes the key code into a DEPTH-entry FIFO.
- The CPU reads the FIFO through a two-address port: a status port and a data port. Reading the data port pops one entry.
- Adds buffering, overflow detection, an interrupt request and a fill count, none of which the previous single-entry block had.

Parameters:
DATA_W, 4, key code width; must be >= 3 so the status word fits in data_out
DEPTH, 8, FIFO entries; power of 2, >= 2
SYNC_STAGES, 2, synchroniser flops on kb_strobe; >= 2

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
kb_data  in  DATA_W  key code; held stable by the source while kb_strobe is high
kb_strobe  in  1  asynchronous key-press strobe; level high while a key is pressed
port_id  in  1  port select: 1 = data port, 0 = status port
port_read  in  1  single-cycle read strobe for the selected port
data_out  out  DATA_W  combinational read mux
irq  out  1  high while the FIFO is not empty (registered)
count  out  $clog2(DEPTH)+1  number of occupied entries (registered)

Behaviour:
- Reset: synchronous, active-high, highest priority over all other events.
  - Clears the sync chain, edge register, wr_ptr, rd_ptr, count and overflow.
  - After reset: irq=0, count=0, data_out=0 for either port_id.
  - FIFO RAM contents are don't-care.
  - Reset mid-operation flushes all stored entries.
- Strobe path: kb_strobe feeds SYNC_STAGES flops s[0..N-1], followed by a prev register.
  - push_req = s[N-1] & ~prev.
  - kb_data is sampled on the same edge that performs the write.
  - kb_strobe first sampled high at edge k: entry written at edge k+SYNC_STAGES; irq and count reflect it from that edge.
  - A strobe held high through reset release counts as one new press.
  - One press (any length of high level) produces exactly one push.
- Pop: pop_req = port_read & port_id & (count != 0).
  - A data read while empty does nothing and returns 0.
- Data port: data_out = head entry if count != 0, else 0. The head is shown combinationally; the pop advances rd_ptr at the same clock edge as the read.
- Status port: data_out = {0…, overflow, full, not_empty}.
  - Bit 0 = not_empty, bit 1 = full (count == DEPTH), bit 2 = overflow.
  - Reading the status port clears overflow.
- Push accounting:
  - push and pop in the same cycle: both occur; count unchanged.
  - Empty with simultaneous push and pop: pop ignored, push taken, count becomes 1.
  - Full with push and no pop: word dropped, overflow set (sticky), count stays DEPTH.
  - Full with push and pop together: both succeed; no overflow.
- overflow set and status-read clear in the same cycle: set wins, so overflow stays 1.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- count saturates naturally in the range 0..DEPTH and never underflows or overflows.
- irq = (count != 0), registered alongside count.

Decomposition:
- Package kb_pkg holds:
  - status bit index constants ST_NEMPTY=0, ST_FULL=1, ST_OVF=2
  - port select constants PORT_STATUS=0, PORT_DATA=1
- Sub-module sync_edge (parameter STAGES): synchroniser chain plus rising-edge pulse output. Reusable by other asynchronous inputs.
- The FIFO storage stays inline as a register array.

Test Plan:
- Reset then one press with kb_data=4'hA → irq rises exactly SYNC_STAGES edges after first sampling; status reads 3'b001; data read returns 4'hA; then irq=0 and count=0.
- Three presses (3, 5, 9), then three data reads → returns 3, 5, 9 in order; count steps 3→2→1→0; a fourth read returns 0 and count stays 0.
- Nine presses with DEPTH=8 → status 3'b111; ninth code dropped; eight reads return the first eight codes; status read clears overflow to 3'b000.
- Full FIFO: align the ninth press's push with a data read → no overflow; count stays 8; wrap-around ordering correct through ≥2 pointer wraps.
- Overflow event in the same cycle as a status read → overflow still 1 on the next status read; key held high for 50 cycles → exactly one push.
- Reset asserted with 5 entries stored → count=0, irq=0, data_out=0; the next press is stored at the head correctly.

Source files
------------

// File: rtl/kb_pkg.sv
// Shared constants for the keypad input FIFO: status word bit positions
// and the port-select encoding used by the CPU read port.
package kb_pkg;

   // Bit positions inside the status word returned on the status port.
   localparam int unsigned ST_NEMPTY = 0;
   localparam int unsigned ST_FULL   = 1;
   localparam int unsigned ST_OVF    = 2;

   // Values of port_id.
   localparam logic PORT_STATUS = 1'b0;
   localparam logic PORT_DATA   = 1'b1;

endpackage : kb_pkg

// File: rtl/sync_edge.sv
// Synchroniser chain for an asynchronous level input, followed by a
// rising-edge detector. The pulse is one cycle wide per low-to-high
// transition seen at the end of the chain.
//   clk     : clock
//   reset   : synchronous, active-high reset
//   async_i : asynchronous level input
//   rise_c  : combinational one-cycle pulse on a synchronised rising edge
module sync_edge #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic async_i,
   output logic rise_c
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;
   logic              prev_q;

   // Shift the raw input into the bottom of the chain.
   always_comb begin
      sync_d = {sync_q[STAGES-2:0], async_i};
   end

   // prev clears on reset, so a level already high at release is a new edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign rise_c = sync_q[STAGES-1] & ~prev_q;

endmodule : sync_edge

// File: rtl/kb_input_fifo.sv
// Keypad input port: synchronises the key strobe, pushes the key code into
// a DEPTH-entry FIFO on every press, and exposes a two-address CPU read
// port (status / data). Reading the data port pops the head entry;
// reading the status port clears the sticky overflow flag.
//   clk       : clock
//   reset     : synchronous, active-high reset
//   kb_data   : key code, stable while kb_strobe is high
//   kb_strobe : asynchronous key-press level
//   port_id   : 1 = data port, 0 = status port
//   port_read : single-cycle read strobe for the selected port
//   data_out  : combinational read mux (head entry or status word)
//   irq       : registered, high while the FIFO holds data
//   count     : registered number of occupied entries
module kb_input_fifo
   import kb_pkg::*;
#(
   parameter int unsigned DATA_W      = 4,
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [DATA_W-1:0]          kb_data,
   input  logic                       kb_strobe,
   input  logic                       port_id,
   input  logic                       port_read,
   output logic [DATA_W-1:0]          data_out,
   output logic                       irq,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q,  count_d;
   logic              ovf_q,    ovf_d;
   logic              irq_q,    irq_d;

   logic push_req_c;
   logic pop_c;
   logic push_c;
   logic not_empty_c;
   logic full_c;
   logic [DATA_W-1:0] data_out_c;

   sync_edge #(
      .STAGES (SYNC_STAGES)
   ) u_strobe_sync (
      .clk     (clk),
      .reset   (reset),
      .async_i (kb_strobe),
      .rise_c  (push_req_c)
   );

   // Push/pop qualification and next-state for pointers, count and flags.
   always_comb begin
      not_empty_c = (count_q != '0);
      full_c      = (count_q == CNT_W'(DEPTH));
      pop_c       = port_read & (port_id == PORT_DATA) & not_empty_c;
      // A full FIFO still accepts a push when a pop frees a slot that cycle.
      push_c      = push_req_c & (~full_c | pop_c);

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
      irq_d   = (count_d != '0);

      // Setting takes priority over the status-read clear.
      ovf_d = ovf_q;
      if (port_read && (port_id == PORT_STATUS)) ovf_d = 1'b0;
      if (push_req_c && !push_c)                 ovf_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         irq_q    <= irq_d;
      end
   end

   // Storage needs no reset; occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (!reset && push_c) mem_q[wr_ptr_q] <= kb_data;
   end

   // Read mux: head entry (0 when empty) or the status word.
   always_comb begin
      data_out_c = '0;
      if (port_id == PORT_DATA) begin
         if (not_empty_c) data_out_c = mem_q[rd_ptr_q];
      end else begin
         data_out_c[ST_NEMPTY] = not_empty_c;
         data_out_c[ST_FULL]   = full_c;
         data_out_c[ST_OVF]    = ovf_q;
      end
   end

   assign data_out = data_out_c;
   assign irq      = irq_q;
   assign count    = count_q;

endmodule : kb_input_fifo

// File: tb/tb_kb_input_fifo.sv
// Directed bench for kb_input_fifo with a read-response scoreboard.
module tb_kb_input_fifo;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] kb_data;
   logic       kb_strobe;
   logic       port_id;
   logic       port_read;
   logic [3:0] data_out;
   logic       irq;
   logic [3:0] count;

   int errors = 0;
   int checks = 0;
   logic [3:0] exp_q [$];

   kb_input_fifo #(
      .DATA_W      (4),
      .DEPTH       (8),
      .SYNC_STAGES (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .kb_data   (kb_data),
      .kb_strobe (kb_strobe),
      .port_id   (port_id),
      .port_read (port_read),
      .data_out  (data_out),
      .irq       (irq),
      .count     (count)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   // Monitor: every read cycle pops one expected value and compares.
   always @(negedge clk) begin
      if (port_read) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL read_unexpected: got %h required <queued expectation>", data_out);
         end else begin
            logic [3:0] e;
            e = exp_q.pop_front();
            if (data_out !== e) begin
               errors++;
               $display("FAIL read_port%0d: got %h required %h at %0t", port_id, data_out, e, $time);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic press(input logic [3:0] code, input int hold);
      @(posedge clk); #1 kb_data = code; kb_strobe = 1'b1;
      repeat (hold) @(posedge clk);
      #1 kb_strobe = 1'b0;
      repeat (4) @(posedge clk);
   endtask

   task automatic rd(input logic pid, input logic [3:0] e);
      @(posedge clk); #1 port_id = pid; port_read = 1'b1; exp_q.push_back(e);
      @(posedge clk); #1 port_read = 1'b0;
   endtask

   task automatic peek(input string name, input logic pid, input logic [3:0] e);
      @(posedge clk); #1 port_id = pid;
      @(negedge clk); check(name, 32'(data_out), 32'(e));
   endtask

   // Ninth press whose push edge coincides with a read of port pid.
   task automatic press_with_read(input logic [3:0] code, input logic pid, input logic [3:0] e);
      @(posedge clk); #1 kb_data = code; kb_strobe = 1'b1;
      @(posedge clk);
      @(posedge clk); #1 port_id = pid; port_read = 1'b1; exp_q.push_back(e);
      @(posedge clk); #1 port_read = 1'b0;
      @(posedge clk); #1 kb_strobe = 1'b0;
      repeat (4) @(posedge clk);
   endtask

   initial begin
      reset = 1'b1; kb_data = '0; kb_strobe = 1'b0; port_id = 1'b0; port_read = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_count", 32'(count), 0);
      check("rst_irq", 32'(irq), 0);
      peek("rst_status", 1'b0, 4'h0);
      peek("rst_data", 1'b1, 4'h0);

      // Single press: irq latency of exactly two edges after first sample.
      @(posedge clk); #1 kb_data = 4'hA; kb_strobe = 1'b1;
      @(posedge clk); @(negedge clk); check("lat_k", 32'(irq), 0);
      @(posedge clk); @(negedge clk); check("lat_k1", 32'(irq), 0);
      @(posedge clk); @(negedge clk); check("lat_k2_irq", 32'(irq), 1);
      check("lat_k2_count", 32'(count), 1);
      @(posedge clk); #1 kb_strobe = 1'b0;
      repeat (4) @(posedge clk);
      rd(1'b0, 4'b0001);
      rd(1'b1, 4'hA);
      @(negedge clk);
      check("t1_irq", 32'(irq), 0);
      check("t1_count", 32'(count), 0);

      // Three presses read back in order, then an empty read.
      press(4'h3, 4); press(4'h5, 4); press(4'h9, 4);
      @(negedge clk); check("t2_count3", 32'(count), 3);
      rd(1'b1, 4'h3); @(negedge clk); check("t2_count2", 32'(count), 2);
      rd(1'b1, 4'h5); @(negedge clk); check("t2_count1", 32'(count), 1);
      rd(1'b1, 4'h9); @(negedge clk); check("t2_count0", 32'(count), 0);
      rd(1'b1, 4'h0); @(negedge clk); check("t2_empty_count", 32'(count), 0);
      check("t2_empty_irq", 32'(irq), 0);

      // Nine presses: ninth dropped, overflow sticky until status read.
      for (int i = 0; i < 9; i++) press(4'(i + 1), 4);
      @(negedge clk); check("t3_count", 32'(count), 8);
      peek("t3_status_full_ovf", 1'b0, 4'b0111);
      for (int i = 0; i < 8; i++) rd(1'b1, 4'(i + 1));
      rd(1'b0, 4'b0100);
      rd(1'b0, 4'b0000);

      // Full FIFO with the ninth push aligned to a data read, then wraps.
      for (int i = 0; i < 8; i++) press(4'(i + 1), 4);
      press_with_read(4'h9, 1'b1, 4'h1);
      @(negedge clk); check("t4_count", 32'(count), 8);
      peek("t4_status_no_ovf", 1'b0, 4'b0011);
      for (int i = 0; i < 8; i++) rd(1'b1, 4'(i + 2));
      for (int i = 0; i < 8; i++) press(4'(15 - i), 4);
      for (int i = 0; i < 8; i++) rd(1'b1, 4'(15 - i));
      @(negedge clk); check("t4_wrap_count", 32'(count), 0);

      // Overflow set in the same cycle as a status read.
      for (int i = 0; i < 8; i++) press(4'(i + 4), 4);
      press_with_read(4'h2, 1'b0, 4'b0011);
      rd(1'b0, 4'b0111);
      rd(1'b0, 4'b0011);
      for (int i = 0; i < 8; i++) rd(1'b1, 4'(i + 4));
      press(4'hC, 50);
      @(negedge clk); check("t5_long_press_count", 32'(count), 1);
      rd(1'b1, 4'hC);
      @(negedge clk); check("t5_after_count", 32'(count), 0);

      // Reset mid-operation flushes stored entries.
      for (int i = 0; i < 5; i++) press(4'(i + 1), 4);
      @(negedge clk); check("t6_pre_count", 32'(count), 5);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check("t6_count", 32'(count), 0);
      check("t6_irq", 32'(irq), 0);
      peek("t6_status", 1'b0, 4'h0);
      peek("t6_data", 1'b1, 4'h0);
      press(4'h6, 4);
      @(negedge clk); check("t6_new_count", 32'(count), 1);
      rd(1'b1, 4'h6);

      repeat (3) @(posedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_kb_input_fifo
